// File: rtl/counter_sequencer.sv
// Up/down count sequencer: one-shot up/down, auto-reload and ping-pong modes.
// Owns the count register; a start latches mode and limit for the whole run.
//
// state | meaning
// IDLE  | waiting for start, count holds last value
// RUN   | stepping the count, endpoint action applied per latched mode
// DONE  | one-cycle completion of a one-shot run (done_o high)
module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             up_down_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_RELOAD = 2'b10;
  localparam logic [1:0] MODE_PING   = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [1:0]       mode_q, mode_d;
  logic             up_down_q, up_down_d;
  logic             wrap_q, wrap_d;
  logic             start_ok;
  logic             at_end;

  assign start_ok = start_i && !stop_i;
  assign at_end   = up_down_q ? (count_q == limit_q) : (count_q == '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      mode_q    <= 2'b00;
      up_down_q <= 1'b1;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      up_down_q <= up_down_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (at_end && (mode_q == MODE_UP || mode_q == MODE_DOWN)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    up_down_d = up_down_q;
    wrap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          mode_d    = mode_i;
          limit_d   = limit_i;
          count_d   = (mode_i == MODE_DOWN) ? limit_i : '0;
          up_down_d = (mode_i != MODE_DOWN);
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          count_d = count_q;
        end else if (at_end) begin
          case (mode_q)
            MODE_RELOAD: begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
            MODE_PING: begin
              wrap_d = 1'b1;
              // A zero limit has no room to reverse: stay at 0, keep direction.
              if (limit_q != '0) begin
                if (up_down_q) begin
                  count_d   = limit_q - WIDTH'(1);
                  up_down_d = 1'b0;
                end else begin
                  count_d   = WIDTH'(1);
                  up_down_d = 1'b1;
                end
              end
            end
            default: count_d = count_q;
          endcase
        end else begin
          count_d = up_down_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
      end
      default: count_d = count_q;
    endcase
  end

  assign count_o   = count_q;
  assign up_down_o = up_down_q;
  assign wrap_o    = wrap_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: vector table plus hand-written
// ping-pong and asynchronous-reset sequences.
module tb_counter_sequencer;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       start_i, stop_i;
  logic [1:0] mode_i;
  logic [7:0] limit_i;
  logic [7:0] count_o;
  logic       up_down_o, busy_o, done_o, wrap_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] limit;
    logic [7:0] c;
    logic       ud;
    logic       b;
    logic       d;
    logic       w;
  } vec_t;

  vec_t vecs[$];

  counter_sequencer #(.WIDTH(8)) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .mode_i    (mode_i),
    .limit_i   (limit_i),
    .count_o   (count_o),
    .up_down_o (up_down_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .wrap_o    (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void add(logic st, logic sp, logic [1:0] m, logic [7:0] l,
                              logic [7:0] c, logic ud, logic b, logic d, logic w);
    vecs.push_back('{st, sp, m, l, c, ud, b, d, w});
  endfunction

  task automatic check(string name, logic [7:0] ec, logic eud, logic eb, logic ed, logic ew);
    n_checks++;
    if (count_o !== ec || up_down_o !== eud || busy_o !== eb || done_o !== ed || wrap_o !== ew) begin
      n_errors++;
      $display("FAIL %s: got count=%0d ud=%0b busy=%0b done=%0b wrap=%0b, want count=%0d ud=%0b busy=%0b done=%0b wrap=%0b",
               name, count_o, up_down_o, busy_o, done_o, wrap_o, ec, eud, eb, ed, ew);
    end
  endtask

  task automatic drive(logic st, logic sp, logic [1:0] m, logic [7:0] l);
    start_i = st;
    stop_i  = sp;
    mode_i  = m;
    limit_i = l;
  endtask

  task automatic run_vecs(int first, int last);
    for (int i = first; i <= last; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].limit);
      @(posedge clk_i);
      #1;
      check($sformatf("vec[%0d]", i), vecs[i].c, vecs[i].ud, vecs[i].b, vecs[i].d, vecs[i].w);
    end
  endtask

  initial begin
    logic [7:0] pp_c[11]  = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    logic       pp_ud[11] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    logic       pp_w[11]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    // mode 00, L=5 (rows 0..8)
    add(1, 0, 2'b00, 8'd5, 8'd0, 1, 1, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 2'b00, 8'd5, 8'(k), 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd5, 8'd5, 1, 1, 1, 0);
    add(0, 0, 2'b00, 8'd5, 8'd5, 1, 0, 0, 0);
    add(0, 0, 2'b00, 8'd5, 8'd5, 1, 0, 0, 0);
    // mode 01, L=3, start pulses and input changes during RUN/DONE ignored
    add(1, 0, 2'b01, 8'd3, 8'd3, 0, 1, 0, 0);
    add(1, 0, 2'b00, 8'd7, 8'd2, 0, 1, 0, 0);
    add(0, 0, 2'b10, 8'd7, 8'd1, 0, 1, 0, 0);
    add(1, 0, 2'b00, 8'd9, 8'd0, 0, 1, 0, 0);
    add(0, 0, 2'b00, 8'd9, 8'd0, 0, 1, 1, 0);
    add(1, 0, 2'b00, 8'd2, 8'd0, 0, 0, 0, 0);
    // mode 10, L=2, nine counts then stop
    add(1, 0, 2'b10, 8'd2, 8'd0, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd0, 8'd1, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd0, 8'd2, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd0, 8'd0, 1, 1, 0, 1);
    add(0, 0, 2'b00, 8'd0, 8'd1, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd0, 8'd2, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd0, 8'd0, 1, 1, 0, 1);
    add(0, 0, 2'b00, 8'd0, 8'd1, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd0, 8'd2, 1, 1, 0, 0);
    add(0, 1, 2'b00, 8'd0, 8'd2, 1, 0, 0, 0);
    add(0, 0, 2'b00, 8'd0, 8'd2, 1, 0, 0, 0);
    // L=0, mode 00
    add(1, 0, 2'b00, 8'd0, 8'd0, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd0, 8'd0, 1, 1, 1, 0);
    add(0, 0, 2'b00, 8'd0, 8'd0, 1, 0, 0, 0);
    // L=0, mode 10
    add(1, 0, 2'b10, 8'd0, 8'd0, 1, 1, 0, 0);
    add(0, 0, 2'b10, 8'd0, 8'd0, 1, 1, 0, 1);
    add(0, 0, 2'b10, 8'd0, 8'd0, 1, 1, 0, 1);
    add(0, 1, 2'b10, 8'd0, 8'd0, 1, 0, 0, 0);
    // L=0, mode 11
    add(1, 0, 2'b11, 8'd0, 8'd0, 1, 1, 0, 0);
    add(0, 0, 2'b11, 8'd0, 8'd0, 1, 1, 0, 1);
    add(0, 0, 2'b11, 8'd0, 8'd0, 1, 1, 0, 1);
    add(0, 1, 2'b11, 8'd0, 8'd0, 1, 0, 0, 0);
    // start with stop in IDLE stays idle, then a clean L=1 one-shot
    add(1, 1, 2'b00, 8'd4, 8'd0, 1, 0, 0, 0);
    add(0, 0, 2'b00, 8'd4, 8'd0, 1, 0, 0, 0);
    add(1, 0, 2'b00, 8'd1, 8'd0, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd4, 8'd1, 1, 1, 0, 0);
    add(0, 0, 2'b00, 8'd4, 8'd1, 1, 1, 1, 0);
    add(0, 0, 2'b00, 8'd4, 8'd1, 1, 0, 0, 0);

    drive(0, 0, 2'b00, 8'd0);
    reset_ni = 1'b0;
    #23;
    check("reset_state", 8'd0, 1, 0, 0, 0);
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("after_release", 8'd0, 1, 0, 0, 0);

    run_vecs(0, vecs.size() - 1);

    // ping-pong, L=3
    drive(1, 0, 2'b11, 8'd3);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk_i);
      #1;
      drive(0, 0, 2'b00, 8'd9);
      check($sformatf("pingpong[%0d]", i), pp_c[i], pp_ud[i], 1, 0, pp_w[i]);
    end
    drive(0, 1, 2'b00, 8'd9);
    @(posedge clk_i);
    #1;
    check("pingpong_stop", 8'd2, 0, 0, 0, 0);

    // asynchronous reset mid-RUN of a down count
    drive(1, 0, 2'b01, 8'd6);
    @(posedge clk_i);
    #1;
    drive(0, 0, 2'b01, 8'd6);
    check("pre_reset0", 8'd6, 0, 1, 0, 0);
    @(posedge clk_i);
    #1;
    check("pre_reset1", 8'd5, 0, 1, 0, 0);
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_reset", 8'd0, 1, 0, 0, 0);
    @(posedge clk_i);
    #1;
    check("reset_held", 8'd0, 1, 0, 0, 0);
    #3;
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_reset_idle", 8'd0, 1, 0, 0, 0);
    run_vecs(0, 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Programmable controller for an up/down counter datapath of configurable width.
- Accepts a start command with a latched limit and mode, then sequences the count through one of four modes: one-shot up, one-shot down, auto-reload and ping-pong.
- Drives direction, reports status, and pulses completion and wrap events.
- Sits between the control/register logic and timing consumers (timers, PWM, scan generators) as the single owner of the count register.

Parameters:
- WIDTH, 8, bit width of count_o and limit_i (must be >= 2).

Ports:
- clk_i  input  1  system clock, all logic on the rising edge
- reset_ni  input  1  asynchronous, active-low reset
- start_i  input  1  start request, sampled only in IDLE
- stop_i  input  1  abort request, sampled in RUN
- mode_i  input  2  00 one-shot up, 01 one-shot down, 10 auto-reload up, 11 ping-pong
- limit_i  input  WIDTH  terminal value L, unsigned
- count_o  output  WIDTH  current count (registered)
- up_down_o  output  1  1 = counting up, 0 = counting down (registered)
- busy_o  output  1  high while in RUN or DONE
- done_o  output  1  one-cycle pulse when a one-shot sequence completes
- wrap_o  output  1  one-cycle pulse on reload or direction reversal

Behaviour:
- Reset: reset_ni low asynchronously forces state IDLE and these outputs:
  - count_o = 0
  - up_down_o = 1
  - busy_o, done_o, wrap_o = 0
  - latched mode/limit = 0
- Reset is honoured mid-sequence with no completion pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - count_o holds its last value; busy_o = 0.
  - start_i = 1 and stop_i = 0 latches mode_i and limit_i.
  - Next cycle: enter RUN, busy_o = 1, and count_o loads the start value: L for mode 01, 0 otherwise.
  - up_down_o loads 0 for mode 01, 1 otherwise.
  - start_i and stop_i both high in IDLE: remain in IDLE.
- RUN, evaluated each cycle in priority order:
  1. stop_i = 1: next cycle IDLE, count_o holds, no done_o, no wrap_o.
  2. Count at endpoint (L when up, 0 when down): apply the mode action below.
  3. Otherwise step count_o by +1 (up) or -1 (down).
- Endpoint actions:
  - Modes 00/01: next cycle DONE, count_o holds the endpoint, done_o = 1 for exactly that cycle.
  - Mode 10: next cycle count_o = 0, wrap_o = 1 for that cycle; remain in RUN. Period is L+1 cycles.
  - Mode 11:
    - At L going up: next count_o = L-1, up_down_o = 0, wrap_o = 1.
    - At 0 going down: next count_o = 1, up_down_o = 1, wrap_o = 1.
    - Period is 2L cycles.
- L = 0:
  - Modes 00/01: DONE on the cycle after RUN entry.
  - Modes 10/11: count_o stays 0, wrap_o high every RUN cycle after the first, up_down_o unchanged.
- DONE: lasts one cycle, then IDLE. busy_o stays 1 in DONE. start_i and stop_i are ignored.
- start_i is ignored while busy_o = 1.
- mode_i and limit_i changes after the start are ignored until the next start.
- Arithmetic: unsigned modulo 2^WIDTH. No overflow is reachable since the count is bounded by [0, L].
- Latency from start_i to the first count_o value: 1 cycle. One-shot up, start at T: count_o = k at T+1+k, DONE/done_o at T+2+L, IDLE at T+3+L.
- done_o and wrap_o are never high in the same cycle.

Test Plan:
1. Reset release, then mode 00, L = 5, start pulse at T → count_o 0..5 at T+1..T+6, done_o = 1 only at T+7, busy_o low from T+8, count_o holds 5.
2. Mode 01, L = 3 → count_o 3, 2, 1, 0; up_down_o = 0 throughout; done_o one cycle after 0 is shown; start_i pulses during RUN ignored.
3. Mode 10, L = 2, run 9 cycles → count_o 0, 1, 2, 0, 1, 2, 0, 1, 2 with wrap_o coincident with each reload to 0; stop_i then → IDLE next cycle, count holds, no done_o.
4. Mode 11, L = 3 → count_o 0, 1, 2, 3, 2, 1, 0, 1, 2, ...; up_down_o falls with count_o = 2 (first down step) and rises with count_o = 1 (first up step); wrap_o on both reversals.
5. Edge cases:
   - L = 0 in mode 00 → done_o on the second RUN cycle.
   - L = 0 in mode 10 → count_o stuck at 0 with continuous wrap_o.
   - start_i and stop_i together in IDLE → stays IDLE.
6. Assert reset_ni low asynchronously mid-RUN (between clock edges) → all outputs take reset values immediately; after release, a new start behaves as in scenario 1.
